pc_sequencer: RTL

Program-counter stage of the single-cycle MIPS core: holds the PC, computes the next PC (sequential, conditional branch, J/JAL, JR) and implements the syscall halt/resume protocol. It feeds the instruction ROM and supplies `PC_plus_4` to the write-back mux. It consumes the sign-extended branch offset (`ext18`), the register-file read port 1 value and the decoder control bits. It also keeps retired-instruction, jump and taken-branch counters for the board display.

---
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Bus between the pc_sequencer and the surrounding core: decoder/datapath
// inputs plus PC, halt status and statistics counters flowing back out.
interface pc_sequencer_if #(
    parameter int CNT_W = 32
);
    logic              Go;
    logic              Syscall;
    logic [31:0]       R1_out;
    logic [31:0]       Order;
    logic [31:0]       ext18;
    logic              Jmp;
    logic              Jal;
    logic              Jr;
    logic              Beq;
    logic              Bne;
    logic              Equal;
    logic [31:0]       PC;
    logic [31:0]       PC_plus_4;
    logic              halted;
    logic              go_pulse;
    logic [CNT_W-1:0]  retired_cnt;
    logic [CNT_W-1:0]  jump_cnt;
    logic [CNT_W-1:0]  branch_cnt;

    modport master (
        output Go, Syscall, R1_out, Order, ext18, Jmp, Jal, Jr, Beq, Bne, Equal,
        input  PC, PC_plus_4, halted, go_pulse, retired_cnt, jump_cnt, branch_cnt
    );

    modport slave (
        input  Go, Syscall, R1_out, Order, ext18, Jmp, Jal, Jr, Beq, Bne, Equal,
        output PC, PC_plus_4, halted, go_pulse, retired_cnt, jump_cnt, branch_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage of the single-cycle MIPS core: next-PC selection,
// syscall halt/resume on a synchronized Go button, and retire statistics.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);
    localparam logic [0:0]       ST_RUN   = 1'b0;
    localparam logic [0:0]       ST_HALT  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      PRINT_V0 = 32'h0000_0022;

    logic [0:0]       state_r;
    logic [31:0]      pc_r;
    logic             g1_r;
    logic             g2_r;
    logic             g3_r;
    logic             v1_r;
    logic             v2_r;
    logic             armed_r;
    logic [CNT_W-1:0] retired_r;
    logic [CNT_W-1:0] jump_r;
    logic [CNT_W-1:0] branch_r;

    logic [31:0]      pc_plus_4_s;
    logic             taken_s;
    logic             jump_any_s;
    logic             go_pulse_s;
    logic [31:0]      target_s;
    logic [0:0]       state_nxt_s;
    logic [31:0]      pc_nxt_s;
    logic             advance_s;
    logic             count_jump_s;
    logic             count_branch_s;

    assign pc_plus_4_s = pc_r + 32'd4;
    assign taken_s     = (bus.Beq & bus.Equal) | (bus.Bne & ~bus.Equal);
    assign jump_any_s  = bus.Jr | bus.Jmp | bus.Jal;
    // armed_r blocks a spurious edge when reset releases while Go is still held
    assign go_pulse_s  = g2_r & ~g3_r & armed_r;

    // Next-PC target selection: JR over J/JAL over taken branch over sequential.
    always_comb begin
        target_s = pc_plus_4_s;
        if (bus.Jr) begin
            target_s = bus.R1_out;
        end else if (bus.Jmp | bus.Jal) begin
            target_s = {pc_plus_4_s[31:28], bus.Order[25:0], 2'b00};
        end else if (taken_s) begin
            target_s = pc_plus_4_s + bus.ext18;
        end else begin
            target_s = pc_plus_4_s;
        end
    end

    // RUN/HALT sequencing and decision of whether this cycle retires.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        advance_s      = 1'b0;
        count_jump_s   = 1'b0;
        count_branch_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (bus.Syscall) begin
                    if (bus.R1_out == PRINT_V0) begin
                        pc_nxt_s  = pc_plus_4_s;
                        advance_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_HALT;
                    end
                end else begin
                    pc_nxt_s       = target_s;
                    advance_s      = 1'b1;
                    count_jump_s   = jump_any_s;
                    count_branch_s = taken_s & ~jump_any_s;
                end
            end
            ST_HALT: begin
                if (go_pulse_s) begin
                    pc_nxt_s    = pc_plus_4_s;
                    state_nxt_s = ST_RUN;
                    advance_s   = 1'b1;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                pc_nxt_s    = pc_r;
            end
        endcase
    end

    // Go synchronizer, edge detector and post-reset arming.
    always_ff @(posedge clk) begin
        if (rst) begin
            g1_r    <= 1'b0;
            g2_r    <= 1'b0;
            g3_r    <= 1'b0;
            v1_r    <= 1'b0;
            v2_r    <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            g1_r    <= bus.Go;
            g2_r    <= g1_r;
            g3_r    <= g2_r;
            v1_r    <= 1'b1;
            v2_r    <= v1_r;
            armed_r <= armed_r | (v2_r & ~g2_r);
        end
    end

    // PC, state and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_RUN;
            pc_r      <= RESET_PC;
            retired_r <= {CNT_W{1'b0}};
            jump_r    <= {CNT_W{1'b0}};
            branch_r  <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            if (advance_s) begin
                retired_r <= retired_r + CNT_ONE;
            end
            if (count_jump_s) begin
                jump_r <= jump_r + CNT_ONE;
            end
            if (count_branch_s) begin
                branch_r <= branch_r + CNT_ONE;
            end
        end
    end

    assign bus.PC          = pc_r;
    assign bus.PC_plus_4   = pc_plus_4_s;
    assign bus.halted      = (state_r == ST_HALT);
    assign bus.go_pulse    = go_pulse_s;
    assign bus.retired_cnt = retired_r;
    assign bus.jump_cnt    = jump_r;
    assign bus.branch_cnt  = branch_r;
endmodule
